// File: rtl/multi_lane_segmenter_pkg.sv
// Shared definitions for the multi-lane segmenter.
//   phase_t       : lane phase, SKIP (first region) or PASS (main region)
//   DEF_SKIP_LEN  : default reset value of a lane's active skip length
//   DEF_SEG_LEN   : default reset value of a lane's active segment length
//   lane_lo()     : low bit index of lane 'lane' inside a packed per-lane bus
package multi_lane_segmenter_pkg;

  typedef enum logic {
    PH_SKIP = 1'b0,
    PH_PASS = 1'b1
  } phase_t;

  localparam int DEF_SKIP_LEN = 5000;
  localparam int DEF_SEG_LEN  = 31250;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/multi_lane_segmenter_if.sv
// Stream bundle of the multi-lane segmenter: one input stream and two output
// streams (main and first/skip region), each NUM_LANES lanes wide and packed
// with lane i at [i*DATA_W +: DATA_W] for data, bit i for the scalar controls.
//   master : the segmenter's view (consumes s_axis, drives m_axis/m_first_axis)
//   slave  : the surrounding environment's view (the mirror image)
interface multi_lane_segmenter_if #(
  parameter int NUM_LANES = 5,
  parameter int DATA_W    = 76
);
  logic [NUM_LANES*DATA_W-1:0] s_axis_tdata;
  logic [NUM_LANES-1:0]        s_axis_tvalid;
  logic [NUM_LANES-1:0]        s_axis_tlast;
  logic [NUM_LANES-1:0]        s_axis_tready;

  logic [NUM_LANES*DATA_W-1:0] m_axis_tdata;
  logic [NUM_LANES-1:0]        m_axis_tvalid;
  logic [NUM_LANES-1:0]        m_axis_tlast;
  logic [NUM_LANES-1:0]        m_axis_tready;

  logic [NUM_LANES*DATA_W-1:0] m_first_axis_tdata;
  logic [NUM_LANES-1:0]        m_first_axis_tvalid;
  logic [NUM_LANES-1:0]        m_first_axis_tlast;
  logic [NUM_LANES-1:0]        m_first_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready,
    output m_first_axis_tdata, m_first_axis_tvalid, m_first_axis_tlast,
    input  m_first_axis_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready,
    input  m_first_axis_tdata, m_first_axis_tvalid, m_first_axis_tlast,
    output m_first_axis_tready
  );
endinterface

// File: rtl/multi_lane_segmenter_segment_lane.sv
// One segmenter lane: splits each input frame into a skip region (first port)
// and a main region (main port) re-framed into seg_len-sample segments.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_skip_len, cfg_seg_len       new lengths, captured into the shadow on cfg_load
//   s_tdata/s_tvalid/s_tlast/s_tready   input stream
//   m_*                             main-region output stream
//   f_*                             first (skip) region output stream
//   frame_err                       1-cycle pulse: frame ended inside the skip region
module segment_lane
  import multi_lane_segmenter_pkg::*;
#(
  parameter int DATA_W   = 76,
  parameter int CNT_W    = 16,
  parameter int DEF_SKIP = DEF_SKIP_LEN,
  parameter int DEF_SEG  = DEF_SEG_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cfg_skip_len,
  input  logic [CNT_W-1:0]  cfg_seg_len,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [DATA_W-1:0] f_tdata,
  output logic              f_tvalid,
  output logic              f_tlast,
  input  logic              f_tready,
  output logic              frame_err
);
  localparam logic [CNT_W-1:0] DEF_SKIP_V = CNT_W'(DEF_SKIP);
  localparam logic [CNT_W-1:0] DEF_SEG_V  = CNT_W'(DEF_SEG);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  phase_t             phase_reg, phase_next;
  logic [CNT_W-1:0]   skip_cnt_reg, skip_cnt_next;
  logic [CNT_W-1:0]   seg_cnt_reg, seg_cnt_next;
  logic [CNT_W-1:0]   act_skip_reg, act_skip_next;
  logic [CNT_W-1:0]   act_seg_reg, act_seg_next;
  logic [CNT_W-1:0]   shd_skip_reg, shd_skip_next;
  logic [CNT_W-1:0]   shd_seg_reg, shd_seg_next;
  logic               pending_reg, pending_next;
  logic               hold_valid_reg, hold_valid_next;
  logic [DATA_W-1:0]  hold_data_reg, hold_data_next;
  logic               hold_last_reg, hold_last_next;
  logic               hold_dest_reg, hold_dest_next;   // 0: first port, 1: main port
  logic               frame_err_reg, frame_err_next;

  logic accept, frame_start, skip_at_end, seg_at_end;

  // The holding register frees up in the same cycle it is drained, so input
  // readiness follows the selected downstream ready combinationally.
  assign s_tready = ~hold_valid_reg | (hold_dest_reg ? m_tready : f_tready);
  assign accept   = s_tvalid & s_tready;

  // SKIP is only ever entered with a non-zero skip length, so skip_len-1 is safe.
  assign skip_at_end = (skip_cnt_reg == act_skip_reg - ONE);
  // A zero segment length disables segment-based tlast entirely.
  assign seg_at_end  = (act_seg_reg != '0) && (seg_cnt_reg == act_seg_reg - ONE);

  assign f_tvalid  = hold_valid_reg & ~hold_dest_reg;
  assign m_tvalid  = hold_valid_reg & hold_dest_reg;
  assign f_tlast   = f_tvalid & hold_last_reg;
  assign m_tlast   = m_tvalid & hold_last_reg;
  assign f_tdata   = hold_data_reg;
  assign m_tdata   = hold_data_reg;
  assign frame_err = frame_err_reg;

  always_comb begin
    phase_next      = phase_reg;
    skip_cnt_next   = skip_cnt_reg;
    seg_cnt_next    = seg_cnt_reg;
    act_skip_next   = act_skip_reg;
    act_seg_next    = act_seg_reg;
    shd_skip_next   = shd_skip_reg;
    shd_seg_next    = shd_seg_reg;
    pending_next    = pending_reg;
    hold_valid_next = hold_valid_reg;
    hold_data_next  = hold_data_reg;
    hold_last_next  = hold_last_reg;
    hold_dest_next  = hold_dest_reg;
    frame_err_next  = 1'b0;
    frame_start     = 1'b0;

    if (hold_valid_reg && (hold_dest_reg ? m_tready : f_tready)) begin
      hold_valid_next = 1'b0;
    end

    if (accept) begin
      hold_valid_next = 1'b1;
      hold_data_next  = s_tdata;
      if (phase_reg == PH_SKIP) begin
        hold_dest_next = 1'b0;
        hold_last_next = skip_at_end | s_tlast;
        if (s_tlast) begin
          frame_start    = 1'b1;
          frame_err_next = (skip_cnt_reg < act_skip_reg - ONE);
        end else if (skip_at_end) begin
          phase_next    = PH_PASS;
          skip_cnt_next = '0;
        end else begin
          skip_cnt_next = skip_cnt_reg + ONE;
        end
      end else begin
        hold_dest_next = 1'b1;
        hold_last_next = seg_at_end | s_tlast;
        if (s_tlast) begin
          frame_start = 1'b1;
        end else if (seg_at_end) begin
          seg_cnt_next = '0;
        end else begin
          seg_cnt_next = seg_cnt_reg + ONE;
        end
      end
    end

    // Frame start consumes the shadow captured before this beat; a cfg_load in
    // the same cycle lands in the shadow afterwards and waits one more frame.
    if (frame_start) begin
      skip_cnt_next = '0;
      seg_cnt_next  = '0;
      if (pending_reg) begin
        act_skip_next = shd_skip_reg;
        act_seg_next  = shd_seg_reg;
        pending_next  = 1'b0;
      end
      phase_next = (act_skip_next == '0) ? PH_PASS : PH_SKIP;
    end

    if (cfg_load) begin
      shd_skip_next = cfg_skip_len;
      shd_seg_next  = cfg_seg_len;
      pending_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg      <= (DEF_SKIP_V == '0) ? PH_PASS : PH_SKIP;
      skip_cnt_reg   <= '0;
      seg_cnt_reg    <= '0;
      act_skip_reg   <= DEF_SKIP_V;
      act_seg_reg    <= DEF_SEG_V;
      shd_skip_reg   <= '0;
      shd_seg_reg    <= '0;
      pending_reg    <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      hold_last_reg  <= 1'b0;
      hold_dest_reg  <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      phase_reg      <= phase_next;
      skip_cnt_reg   <= skip_cnt_next;
      seg_cnt_reg    <= seg_cnt_next;
      act_skip_reg   <= act_skip_next;
      act_seg_reg    <= act_seg_next;
      shd_skip_reg   <= shd_skip_next;
      shd_seg_reg    <= shd_seg_next;
      pending_reg    <= pending_next;
      hold_valid_reg <= hold_valid_next;
      hold_data_reg  <= hold_data_next;
      hold_last_reg  <= hold_last_next;
      hold_dest_reg  <= hold_dest_next;
      frame_err_reg  <= frame_err_next;
    end
  end
endmodule

// File: rtl/multi_lane_segmenter.sv
// NUM_LANES independent segmenter lanes behind one stream bundle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_skip_len      per-lane skip length, lane i at [i*CNT_W +: CNT_W]
//   cfg_seg_len       per-lane segment length, same packing
//   cfg_load          per-lane shadow load pulse
//   bus               input stream plus main and first-region output streams
//   frame_err         per-lane short-frame pulse
module multi_lane_segmenter
  import multi_lane_segmenter_pkg::*;
#(
  parameter int NUM_LANES = 5,
  parameter int DATA_W    = 76,
  parameter int CNT_W     = 16,
  parameter int DEF_SKIP  = DEF_SKIP_LEN,
  parameter int DEF_SEG   = DEF_SEG_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*CNT_W-1:0] cfg_skip_len,
  input  logic [NUM_LANES*CNT_W-1:0] cfg_seg_len,
  input  logic [NUM_LANES-1:0]       cfg_load,
  multi_lane_segmenter_if.master     bus,
  output logic [NUM_LANES-1:0]       frame_err
);
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam int CLO = lane_lo(gi, CNT_W);
    localparam int DLO = lane_lo(gi, DATA_W);

    segment_lane #(
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W),
      .DEF_SKIP(DEF_SKIP),
      .DEF_SEG (DEF_SEG)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .cfg_skip_len(cfg_skip_len[CLO +: CNT_W]),
      .cfg_seg_len (cfg_seg_len[CLO +: CNT_W]),
      .cfg_load    (cfg_load[gi]),
      .s_tdata     (bus.s_axis_tdata[DLO +: DATA_W]),
      .s_tvalid    (bus.s_axis_tvalid[gi]),
      .s_tlast     (bus.s_axis_tlast[gi]),
      .s_tready    (bus.s_axis_tready[gi]),
      .m_tdata     (bus.m_axis_tdata[DLO +: DATA_W]),
      .m_tvalid    (bus.m_axis_tvalid[gi]),
      .m_tlast     (bus.m_axis_tlast[gi]),
      .m_tready    (bus.m_axis_tready[gi]),
      .f_tdata     (bus.m_first_axis_tdata[DLO +: DATA_W]),
      .f_tvalid    (bus.m_first_axis_tvalid[gi]),
      .f_tlast     (bus.m_first_axis_tlast[gi]),
      .f_tready    (bus.m_first_axis_tready[gi]),
      .frame_err   (frame_err[gi])
    );
  end
endmodule
